communication_receive: RTL

//  Serial receiver on FPGA2 for the rainfall link driven by the FPGA1 sender's sd line.

---
 rtl/communication_receive_if.sv | 22 ++
 rtl/communication_receive.sv | 120 ++++++++++++
 2 files changed

// File: rtl/communication_receive_if.sv
// Signal bundle between the rainfall-link receiver and its surroundings.
// The master side drives enable and serial data and observes the results.
interface communication_receive_if;
  logic       rec_en;
  logic       sd;
  logic [7:0] rec_data;
  logic       rec_valid;
  logic       parity_err;
  logic       frame_err;
  logic       busy;
  logic       finish_send;

  modport master (
    output rec_en, sd,
    input  rec_data, rec_valid, parity_err, frame_err, busy, finish_send
  );

  modport slave (
    input  rec_en, sd,
    output rec_data, rec_valid, parity_err, frame_err, busy, finish_send
  );
endinterface

// File: rtl/communication_receive.sv
// Serial receiver for the FPGA1 rainfall link: start, 8 data bits LSB first,
// even parity, stop. Reports good frames, parity and framing errors.
module communication_receive #(
  parameter int BIT_CYCLES = 16
) (
  input logic clk,
  input logic rst,
  communication_receive_if.slave bus
);

  localparam int HALF = BIT_CYCLES / 2;
  localparam int CW   = $clog2(BIT_CYCLES);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} state_t;

  state_t        state, state_n;
  logic          sd_meta, sd_s, sd_d;
  logic [CW-1:0] cyc_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par_bit;
  logic [7:0]    rec_data_q;
  logic          rec_valid_q, parity_err_q, frame_err_q, finish_send_q;
  logic          fall, sample;
  logic          good_frame, bad_parity, bad_stop;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // The start bit is sampled half a bit after the edge, every later bit one
  // full bit after the previous sample, so each lands mid-bit.
  always_comb begin
    fall       = sd_d & ~sd_s;
    sample     = (state == START) ? (cyc_cnt == CW'(HALF - 1))
                                  : (cyc_cnt == CW'(BIT_CYCLES - 1));
    state_n    = state;
    good_frame = 1'b0;
    bad_parity = 1'b0;
    bad_stop   = 1'b0;
    if (!bus.rec_en) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE:      if (fall && !finish_send_q) state_n = START;
        START:     if (sample) state_n = sd_s ? IDLE : DATA;
        DATA:      if (sample && bit_cnt == 3'd7) state_n = PARITY;
        PARITY:    if (sample) state_n = STOP;
        STOP: begin
          if (sample) begin
            if (!sd_s) begin
              bad_stop = 1'b1;
              state_n  = WAIT_IDLE;
            end else if ((^shreg) == par_bit) begin
              good_frame = 1'b1;
              state_n    = IDLE;
            end else begin
              bad_parity = 1'b1;
              state_n    = IDLE;
            end
          end
        end
        WAIT_IDLE: if (sd_s) state_n = IDLE;
        default:   state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sd_meta       <= 1'b1;
      sd_s          <= 1'b1;
      sd_d          <= 1'b1;
      cyc_cnt       <= '0;
      bit_cnt       <= '0;
      shreg         <= '0;
      par_bit       <= 1'b0;
      rec_data_q    <= '0;
      rec_valid_q   <= 1'b0;
      parity_err_q  <= 1'b0;
      frame_err_q   <= 1'b0;
      finish_send_q <= 1'b0;
    end else begin
      sd_meta <= bus.sd;
      sd_s    <= sd_meta;
      sd_d    <= sd_s;
      // Counter restarts on every state change and every sample point.
      if (state_n != state || sample || state == IDLE || state == WAIT_IDLE)
        cyc_cnt <= '0;
      else
        cyc_cnt <= cyc_cnt + CW'(1);
      if (state == IDLE)
        bit_cnt <= '0;
      else if (state == DATA && sample)
        bit_cnt <= bit_cnt + 3'd1;
      if (state == DATA && sample)
        shreg <= {sd_s, shreg[7:1]};
      if (state == PARITY && sample)
        par_bit <= sd_s;
      rec_valid_q  <= good_frame;
      parity_err_q <= bad_parity;
      frame_err_q  <= bad_stop;
      if (good_frame)
        rec_data_q <= shreg;
      if (!bus.rec_en)
        finish_send_q <= 1'b0;
      else if (good_frame)
        finish_send_q <= 1'b1;
    end
  end

  assign bus.rec_data    = rec_data_q;
  assign bus.rec_valid   = rec_valid_q;
  assign bus.parity_err  = parity_err_q;
  assign bus.frame_err   = frame_err_q;
  assign bus.finish_send = finish_send_q;
  assign bus.busy        = (state != IDLE);

endmodule
